// File: rtl/bcd_conv_seq_if.sv
// bcd_conv_seq_if -- handshake/data bundle for the sequential binary-to-BCD
// converter.
//   start  : request a conversion of bin (honoured only while idle)
//   bin    : unsigned binary word, IN_W bits
//   busy   : conversion in progress
//   done   : one-cycle pulse, bcd/err valid and freshly updated
//   bcd    : packed BCD, digit 0 (ones) in [3:0], held until next done
//   err    : error flag of the last conversion
// master drives start/bin (requester side); slave is the converter side.
interface bcd_conv_seq_if #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned DIGITS = 10
);
  logic                  start;
  logic [IN_W-1:0]       bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  err;

  modport master (
    output start, bin,
    input  busy, done, bcd, err
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, err
  );
endinterface

// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq -- sequential binary-to-BCD converter (double dabble, one bit
// per clock) feeding the seven-segment display path.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : bcd_conv_seq_if.slave (start, bin in; busy, done, bcd, err out)
//
// A conversion accepted on edge 0 keeps busy high for IN_W cycles; done and
// the new bcd appear in the cycle after edge IN_W, and the block is idle
// again after edge IN_W+1. bcd/err hold their value between done pulses.
//
// Optional feature macro: BCD_ERR_DETECT_EN
//   defined   : an all-ones bin produces bcd = all 0xF digits and err = 1
//   undefined : err is tied 0 and all-ones converts numerically
module bcd_conv_seq #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_conv_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    bin_q,   bin_d;
  logic [BCD_W-1:0]   scr_q,   scr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  // Scratch after the add-3 correction, and after the subsequent shift.
  logic [BCD_W-1:0]   scr_adj;
  logic [BCD_W-1:0]   scr_shift;

`ifdef BCD_ERR_DETECT_EN
  logic               err_q,   err_d;
  // Remembers that the accepted word was the all-ones error code.
  logic               ones_q,  ones_d;
`endif

  // Add-3 correction per digit: any digit >= 5 would become >= 10 after the
  // shift, so pre-adding 3 makes the shift carry into the next digit.
  always_comb begin
    scr_adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // {scratch, binreg} shifted left by one: the binary MSB enters digit 0.
  always_comb begin
    scr_shift = {scr_adj[BCD_W-2:0], bin_q[IN_W-1]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef BCD_ERR_DETECT_EN
    err_d   = err_q;
    ones_d  = ones_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          bin_d   = bus.bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
`ifdef BCD_ERR_DETECT_EN
          ones_d  = &bus.bin;
`endif
        end
      end

      ST_SHIFT: begin
        scr_d = scr_shift;
        bin_d = {bin_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // Last bit: the fully shifted scratch is the result, published on
        // the same edge that leaves SHIFT.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
`ifdef BCD_ERR_DETECT_EN
          if (ones_q) begin
            bcd_d = '1;
            err_d = 1'b1;
          end else begin
            bcd_d = scr_shift;
            err_d = 1'b0;
          end
`else
          bcd_d = scr_shift;
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore outputs decoded from the next state so they are registered
    // alongside it.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_ERR_DETECT_EN
      err_q   <= 1'b0;
      ones_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_ERR_DETECT_EN
      err_q   <= err_d;
      ones_q  <= ones_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
`ifdef BCD_ERR_DETECT_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_seq.sv
// tb_bcd_conv_seq -- self-checking bench for bcd_conv_seq (IN_W=32, DIGITS=10).
// A cycle-level reference model derived from the conversion rules (decimal
// digits by repeated division, fixed latency counts) is compared against the
// DUT outputs on every falling clock edge; directed vectors additionally pin
// results to hand-computed literals.
module tb_bcd_conv_seq;

  localparam int unsigned IN_W   = 32;
  localparam int unsigned DIGITS = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  bcd_conv_seq_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  bcd_conv_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int              m_age  = -1;     // -1 idle, else edges since acceptance
  logic [31:0]     m_val  = '0;
  logic [39:0]     m_bcd  = '0;
  logic            m_err  = 1'b0;

  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    longint unsigned x;
    logic [39:0] r;
    x = longint'(v);
    r = '0;
`ifdef BCD_ERR_DETECT_EN
    if (v == 32'hFFFF_FFFF) return {40{1'b1}};
`endif
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic err_of(input logic [31:0] v);
`ifdef BCD_ERR_DETECT_EN
    return (v == 32'hFFFF_FFFF);
`else
    return 1'b0 & v[0];
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = -1;
      m_val = '0;
      m_bcd = '0;
      m_err = 1'b0;
    end else if (m_age < 0) begin
      if (bus.start === 1'b1) begin
        m_age = 0;
        m_val = bus.bin;
      end
    end else begin
      m_age = m_age + 1;
      if (m_age == int'(IN_W)) begin
        m_bcd = to_bcd(m_val);
        m_err = err_of(m_val);
      end else if (m_age == int'(IN_W) + 1) begin
        m_age = -1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_age >= 0 && m_age < int'(IN_W)));
    chk("done", 64'(bus.done), 64'(m_age == int'(IN_W)));
    chk("bcd",  64'(bus.bcd),  64'(m_bcd));
    chk("err",  64'(bus.err),  64'(m_err));
    if (bus.done === 1'b1) n_done++;
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int k);
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (bus.done === 1'b1) seen = 1;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic convert(input logic [31:0] v, input logic [39:0] exp_bcd,
                         input logic exp_err, input string name);
    int k;
    bus.start = 1'b1;
    bus.bin   = v;
    tick();
    bus.start = 1'b0;
    bus.bin   = $urandom;          // must not disturb the accepted value
    wait_done(k);
    chk({name, "_latency"}, 64'(k), 64'(IN_W));
    chk({name, "_bcd"}, 64'(bus.bcd), 64'(exp_bcd));
    chk({name, "_err"}, 64'(bus.err), 64'(exp_err));
    tick();                        // DONE -> IDLE
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    bus.start = 1'b0;
    bus.bin   = '0;
    rst_n     = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_bcd",  64'(bus.bcd),  64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Model pins against literals.
    chk("model_12345", 64'(to_bcd(32'd12345)), 64'h00_0001_2345);
    chk("model_sq",    64'(to_bcd(32'd4294836225)), 64'h42_9483_6225);

    convert(32'd0,          40'h00_0000_0000, 1'b0, "zero");
    convert(32'd12345,      40'h00_0001_2345, 1'b0, "n12345");
    convert(32'd4294836225, 40'h42_9483_6225, 1'b0, "sq65535");
`ifdef BCD_ERR_DETECT_EN
    convert(32'hFFFF_FFFF,  40'hFF_FFFF_FFFF, 1'b1, "allones");
`else
    convert(32'hFFFF_FFFF,  40'h42_9496_7295, 1'b0, "allones");
`endif
    convert(32'd7,          40'h00_0000_0007, 1'b0, "seven");

    // start pulsed mid-conversion must be ignored.
    d0 = n_done;
    bus.start = 1'b1;
    bus.bin   = 32'd99;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.bin   = 32'd5;
    tick();
    bus.start = 1'b0;
    wait_done(k);
    chk("ignore_latency", 64'(k), 64'(IN_W - 10));
    chk("ignore_bcd", 64'(bus.bcd), 64'h00_0000_0099);
    repeat (4) tick();
    chk("ignore_one_done", 64'(n_done - d0), 64'd1);

    // start held high: back-to-back conversions every IN_W+2 cycles.
    bus.start = 1'b1;
    bus.bin   = 32'd1;
    tick();
    for (int n = 0; n < 4; n++) begin
      bus.bin = (n % 2 == 0) ? 32'd2 : 32'd1;
      repeat (IN_W) tick();
      chk("b2b_done", 64'(bus.done), 64'd1);
      chk("b2b_bcd", 64'(bus.bcd), (n % 2 == 0) ? 64'h1 : 64'h2);
      if (n == 3) bus.start = 1'b0;
      repeat (2) tick();
    end
    repeat (2) tick();

    // Asynchronous reset in the middle of a conversion of 500.
    bus.start = 1'b1;
    bus.bin   = 32'd500;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_bcd",  64'(bus.bcd),  64'd0);
    chk("arst_err",  64'(bus.err),  64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    d0 = n_done;
    repeat (40) tick();
    chk("arst_no_done", 64'(n_done - d0), 64'd0);
    convert(32'd42, 40'h00_0000_0042, 1'b0, "n42");

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_conv_seq.md
# bcd_conv_seq

Sequential binary-to-BCD converter that consumes the 32-bit result word of the arithmetic unit and produces packed BCD digits for the seven-segment display driver. It uses shift-and-add-3 (double dabble), one bit per clock. A start/busy/done handshake lets the display path latch a new ALU result only when the previous conversion has finished. The converted value is held stable between conversions.

## Interface
- IN_W, 32, binary input width in bits.
- DIGITS, 10, number of BCD output digits. Must be at least ceil(IN_W·log10 2); 10 for IN_W=32.
- clk  input  1  rising-edge clock; the only clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of `bin`; sampled only in IDLE.
- bin  input  IN_W  unsigned binary value, e.g. the ALU result word; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  single-cycle pulse; `bcd` and `err` are valid and updated in this cycle.
- bcd  output  4·DIGITS  packed BCD, digit 0 (ones) in bits [3:0]; held until the next done.
- err  output  1  error flag for the last conversion; only meaningful when BCD_ERR_DETECT_EN is defined, otherwise tied 0.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: performs the conversion.
  - DONE: outputs the result.
- IDLE → SHIFT when start=1 on a clock edge.
  - On that edge, load the internal binary shift register with `bin`, clear the internal BCD scratch register, and load the bit counter with IN_W.
- SHIFT, every cycle:
  - Each 4-bit scratch digit ≥5 gets +3.
  - Then {scratch, binreg} shifts left 1, and the counter decrements.
- SHIFT → DONE on the edge where the counter goes 1→0.
  - On that same edge, copy the final scratch value into the `bcd` output register.
- DONE → IDLE unconditionally after one cycle.
- start is ignored in SHIFT and DONE, with no queuing. Changes on `bin` after acceptance have no effect.
- Outputs are registered, and the decode is Moore:
  - busy = (state==SHIFT)
  - done = (state==DONE)
- Arithmetic is unsigned. No digit ever exceeds 9 for a numeric conversion.
- The scratch register is 4·DIGITS bits wide, and the add-3 step never overflows a digit.
- Reset (asynchronous, any state, including mid-conversion):
  - state=IDLE; busy=0, done=0, bcd=0, err=0.
  - Internal registers are cleared and the partial conversion is discarded.
  - After rst_n deasserts, the block is in IDLE on the first clock edge.

## Timing
- Edge 0 = the edge where start is sampled high in IDLE.
- busy is high from after edge 0 through edge IN_W (IN_W cycles).
- done and the new `bcd` are valid in the cycle after edge IN_W, i.e. IN_W+1 cycles after edge 0. That is cycle 33 for IN_W=32.
- IDLE resumes after edge IN_W+1. The earliest next acceptance is at edge IN_W+2. Minimum start-to-start spacing is IN_W+2 cycles (34).
- start held high continuously gives back-to-back conversions every IN_W+2 cycles.
- start asserted during the done cycle is ignored. It is accepted on the next edge only if still high.

## Configuration
- BCD_ERR_DETECT_EN is a preprocessor macro.
- Defined:
  - If `bin` is all ones at acceptance (0xFFFFFFFF, the divide-by-zero code), the conversion still takes the same IN_W+1 latency.
  - At done, `bcd` = all digits 0xF (display blank/error code) and err=1.
  - Any other value gives err=0 at done.
- Not defined:
  - err is constant 0.
  - All-ones is converted numerically, e.g. bcd=0x4294967295 for IN_W=32.

## Test plan
- Reset, then start with bin=0 → busy high for 32 cycles; done in cycle 33 after acceptance; bcd=0x0000000000; err=0.
- bin=12345 → bcd=0x0000012345; then bin=65535·65535=4294836225 → bcd=0x4294836225.
- bin=0xFFFFFFFF:
  - With BCD_ERR_DETECT_EN → bcd=0xFFFFFFFFFF, err=1.
  - Without → bcd=0x4294967295, err=0.
  - A following bin=7 → bcd=0x0000000007, err=0.
- start=1 with bin=99 accepted, then start pulsed at cycle 10 with bin=5 → ignored; result bcd=0x0000000099; exactly one done pulse.
- start held high, alternating bin 1/2 on each acceptance → done every 34 cycles; bcd alternates 0x…01/0x…02.
- Assert rst_n=0 at cycle 15 of a conversion of 500 → busy, done, bcd, err are 0 immediately (asynchronously); no done follows; the next conversion of 42 gives bcd=0x0000000042.
